wb_timer: RTL and testbench

- Wishbone slave (responder) timer peripheral on the interconnect's timer port (address space with addr[31:30] = 2'b01).
- Provides a 64-bit free-running mtime counter with a programmable prescaler and a 64-bit mtimecmp compare register.
- Raises a level interrupt to the CPU when mtime >= mtimecmp.
- Completes every Wishbone access it receives with a single-cycle registered ack.

---
 rtl/wb_timer.sv | 125 ++++++++++++
 tb/tb_wb_timer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// Wishbone timer: 64-bit prescaled mtime, 64-bit mtimecmp, level irq when mtime >= mtimecmp.
// Latency: registered ack one cycle after a request, irq one cycle after the compare condition.
// Backpressure: none; every request is acked without wait states, so a held strobe gets every other cycle.
module wb_timer #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     irq_o
);

  localparam logic [2:0] A_MTIME_LO    = 3'd0;
  localparam logic [2:0] A_MTIME_HI    = 3'd1;
  localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] A_CTRL        = 3'd4;
  localparam logic [2:0] A_PRESCALE    = 3'd5;

  logic [63:0] mtime;
  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp;
  logic [31:0] prescale;
  logic [31:0] pre_cnt;
  logic [31:0] hi_shadow;
  logic [1:0]  ctrl;
  logic [31:0] rdata;

  logic       req;
  logic       wr;
  logic       rd;
  logic       tick;
  logic [2:0] reg_idx;
  logic       unused_addr;

  assign reg_idx     = wb_addr_i[4:2];
  assign unused_addr = ^{wb_addr_i[WB_ADDR_WIDTH-1:5], wb_addr_i[1:0]};

  assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr   = req & wb_we_i;
  assign rd   = req & ~wb_we_i;
  assign tick = ctrl[0] & (pre_cnt == prescale);

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // A write to either mtime half replaces that cycle's increment, so no carry is applied.
  always_comb begin
    mtime_nxt = mtime;
    if (wr && (reg_idx == A_MTIME_LO || reg_idx == A_MTIME_HI)) begin
      if (reg_idx == A_MTIME_LO) mtime_nxt[31:0]  = merge(mtime[31:0], wb_data_i, wb_sel_i);
      else                       mtime_nxt[63:32] = merge(mtime[63:32], wb_data_i, wb_sel_i);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_idx)
      A_MTIME_LO:    rdata = mtime[31:0];
      A_MTIME_HI:    rdata = hi_shadow;
      A_MTIMECMP_LO: rdata = mtimecmp[31:0];
      A_MTIMECMP_HI: rdata = mtimecmp[63:32];
      A_CTRL:        rdata = {30'd0, ctrl};
      A_PRESCALE:    rdata = prescale;
      default:       rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
      irq_o     <= 1'b0;
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl      <= 2'd0;
      prescale  <= 32'd0;
      pre_cnt   <= 32'd0;
      hi_shadow <= 32'd0;
    end else begin
      wb_ack_o <= req;
      mtime    <= mtime_nxt;
      irq_o    <= ctrl[1] & (mtime >= mtimecmp);

      if (rd) begin
        wb_data_o <= rdata;
        // Snapshot the upper half so a following HI read pairs with this LO read.
        if (reg_idx == A_MTIME_LO) hi_shadow <= mtime[63:32];
      end

      if (wr && reg_idx == A_PRESCALE) pre_cnt <= 32'd0;
      else if (ctrl[0])                pre_cnt <= tick ? 32'd0 : pre_cnt + 32'd1;

      if (wr) begin
        case (reg_idx)
          A_MTIMECMP_LO: mtimecmp[31:0]  <= merge(mtimecmp[31:0], wb_data_i, wb_sel_i);
          A_MTIMECMP_HI: mtimecmp[63:32] <= merge(mtimecmp[63:32], wb_data_i, wb_sel_i);
          A_CTRL:        if (wb_sel_i[0]) ctrl <= wb_data_i[1:0];
          A_PRESCALE:    prescale <= merge(prescale, wb_data_i, wb_sel_i);
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: register access, counting, wrap/shadow, irq timing, byte enables, reset.
module tb_wb_timer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;
  logic        irq_o;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] rd_dat;
  logic        irq_at_ack;
  int          ack_cnt;

  wb_timer dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .wb_we_i   (wb_we_i),
    .wb_sel_i  (wb_sel_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_ack_o  (wb_ack_o),
    .wb_data_o (wb_data_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called 1ns after an edge; request is taken on the next edge, returns 1ns after the edge after that.
  task automatic wb_write(input logic [2:0] idx, input logic [31:0] dat, input logic [3:0] sel);
    wb_addr_i = {27'd0, idx, 2'b00};
    wb_data_i = dat;
    wb_sel_i  = sel;
    wb_we_i   = 1'b1;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    @(posedge clk_i); #1;
    chk("wr_ack", wb_ack_o, 1);
    irq_at_ack = irq_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk_i); #1;
    chk("wr_ack_drop", wb_ack_o, 0);
  endtask

  task automatic wb_read(input logic [2:0] idx, output logic [31:0] dat);
    wb_addr_i = {27'd0, idx, 2'b00};
    wb_we_i   = 1'b0;
    wb_sel_i  = 4'hF;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    @(posedge clk_i); #1;
    chk("rd_ack", wb_ack_o, 1);
    dat = wb_data_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rd_ack_drop", wb_ack_o, 0);
  endtask

  initial begin
    rst_n_i   = 1'b0;
    wb_addr_i = '0;
    wb_data_i = '0;
    wb_we_i   = 1'b0;
    wb_sel_i  = 4'h0;
    wb_stb_i  = 1'b0;
    wb_cyc_i  = 1'b0;
    irq_at_ack = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_dat", wb_data_o, 0);
    chk("rst_irq", irq_o, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset values
    wb_read(3'd4, rd_dat); chk("ctrl_rst", rd_dat, 32'h0);
    wb_read(3'd2, rd_dat); chk("cmp_lo_rst", rd_dat, 32'hFFFF_FFFF);
    wb_read(3'd3, rd_dat); chk("cmp_hi_rst", rd_dat, 32'hFFFF_FFFF);
    chk("irq_idle", irq_o, 0);

    // Prescale 3: mtime steps every 4 cycles; read edge 41 cycles after CTRL write sees 10
    wb_write(3'd5, 32'd3, 4'hF);
    wb_write(3'd4, 32'd1, 4'hF);
    repeat (39) @(posedge clk_i);
    #1;
    wb_read(3'd0, rd_dat); chk("presc3_lo", rd_dat, 32'd10);

    // Prescale 0: one step per cycle
    wb_write(3'd4, 32'd0, 4'hF);
    wb_write(3'd5, 32'd0, 4'hF);
    wb_write(3'd0, 32'd0, 4'hF);
    wb_write(3'd1, 32'd0, 4'hF);
    wb_write(3'd4, 32'd1, 4'hF);
    repeat (10) @(posedge clk_i);
    #1;
    wb_read(3'd0, rd_dat); chk("presc0_lo", rd_dat, 32'd11);

    // Wrap through the LO->HI carry; HI write cycle holds LO and skips the increment
    wb_write(3'd0, 32'hFFFF_FFFE, 4'hF);
    wb_write(3'd1, 32'h0, 4'hF);
    repeat (4) @(posedge clk_i);
    #1;
    wb_read(3'd0, rd_dat); chk("wrap_lo", rd_dat, 32'd4);
    wb_read(3'd1, rd_dat); chk("wrap_hi_shadow", rd_dat, 32'd1);

    // Interrupt timing
    wb_write(3'd4, 32'd0, 4'hF);
    wb_write(3'd0, 32'd0, 4'hF);
    wb_write(3'd1, 32'd0, 4'hF);
    wb_write(3'd3, 32'd0, 4'hF);
    wb_write(3'd2, 32'd100, 4'hF);
    wb_write(3'd4, 32'd3, 4'hF);
    repeat (99) @(posedge clk_i);
    #1;
    chk("irq_at_100", irq_o, 0);
    @(posedge clk_i); #1;
    chk("irq_rise", irq_o, 1);
    wb_write(3'd2, 32'hFFFF_FFFF, 4'hF);
    chk("irq_hold_at_write", irq_at_ack, 1);
    chk("irq_fall", irq_o, 0);

    // Byte enables
    wb_write(3'd2, 32'h1122_3344, 4'b0101);
    wb_read(3'd2, rd_dat); chk("sel_merge", rd_dat, 32'hFF22_FF44);

    // Unmapped slot
    wb_write(3'd6, 32'hDEAD_BEEF, 4'hF);
    wb_read(3'd6, rd_dat); chk("unmapped_rd", rd_dat, 32'h0);

    // Held strobe across 6 edges gives 3 acks
    ack_cnt = 0;
    wb_addr_i = {27'd0, 3'd4, 2'b00};
    wb_we_i = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      if (wb_ack_o) ack_cnt++;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    chk("held_stb_acks", ack_cnt, 3);
    @(posedge clk_i); #1;

    // Reset in the middle of an access with irq asserted
    wb_write(3'd2, 32'h0, 4'hF);
    @(posedge clk_i); #1;
    chk("irq_pre_rst", irq_o, 1);
    wb_addr_i = {27'd0, 3'd4, 2'b00};
    wb_we_i = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid_irq", irq_o, 0);
    chk("rst_mid_ack", wb_ack_o, 0);
    chk("rst_mid_dat", wb_data_o, 0);
    @(posedge clk_i); #1;
    chk("rst_mid_no_ack", wb_ack_o, 0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    wb_read(3'd4, rd_dat); chk("rst_ctrl", rd_dat, 32'h0);
    wb_read(3'd2, rd_dat); chk("rst_cmp_lo", rd_dat, 32'hFFFF_FFFF);
    wb_read(3'd0, rd_dat); chk("rst_mtime_lo", rd_dat, 32'h0);
    wb_read(3'd1, rd_dat); chk("rst_shadow", rd_dat, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
